// File: rtl/snes_reader.sv
// snes_reader: console-side SNES controller port reader.
// Periodically pulses the latch, clocks out 16 serial bits from the pad,
// and publishes the raw active-low word plus a priority-decoded button index.
// Optional feature: define SNES_READER_DEBOUNCE_EN to require two identical
// consecutive frames (that also differ from the current outputs) before the
// outputs update.
module snes_reader #(
  parameter int HALF_CYC = 72,     // system clocks per SNES half-period, >= 4
  parameter int POLL_CYC = 200000  // system clocks spent idle between frames, >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        snes_data,
  output logic        snes_latch,
  output logic        snes_clk,
  output logic [15:0] buttons,
  output logic [3:0]  button_idx,
  output logic        valid,
  output logic        busy
);

  localparam int PW  = $clog2(POLL_CYC + 1);
  localparam int PHW = $clog2(2 * HALF_CYC + 1);

  localparam logic [PW-1:0]  POLL_LAST  = PW'(POLL_CYC - 1);
  localparam logic [PHW-1:0] HALF_LAST  = PHW'(HALF_CYC - 1);
  localparam logic [PHW-1:0] LATCH_LAST = PHW'(2 * HALF_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_GAP,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  poll_q, poll_d;
  logic [PHW-1:0] phase_q, phase_d;
  logic [3:0]     bit_q, bit_d;
  logic [15:0]    shift_q, shift_d;
  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic [15:0]    buttons_q, buttons_d;
  logic [3:0]     idx_q, idx_d;
  logic           valid_q, valid_d;
  logic           latch_q, latch_d;
  logic           sclk_q, sclk_d;
  logic           busy_q, busy_d;
`ifdef SNES_READER_DEBOUNCE_EN
  logic [15:0]    prev_q, prev_d;
`endif
  logic           accept;

  // Lowest-numbered pressed (low) button among bits 0..8, else 4'hF.
  function automatic logic [3:0] prio_idx(input logic [15:0] w);
    prio_idx = 4'hF;
    for (int i = 8; i >= 0; i--) begin
      if (!w[i]) prio_idx = 4'(i);
    end
  endfunction

  // Next-state logic: frame sequencing, bit capture, frame acceptance and
  // output decode from the next state so pad-facing outputs are flop-driven.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    state_d   = state_q;
    poll_d    = poll_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    idx_d     = idx_q;
    valid_d   = 1'b0;
    accept    = 1'b0;
    sync1_d   = snes_data;
    sync2_d   = sync1_q;
`ifdef SNES_READER_DEBOUNCE_EN
    prev_d    = prev_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (poll_q == POLL_LAST) begin
          poll_d  = '0;
          phase_d = '0;
          state_d = S_LATCH;
        end else begin
          poll_d = poll_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          phase_d = '0;
          state_d = S_GAP;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_GAP: begin
        bit_d = '0;
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          state_d = S_SHIFT_LO;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_SHIFT_LO: begin
        // Sample late in the low phase: the pad changed data on the previous
        // rising edge, so the synchronized value has long since settled.
        if (phase_q == HALF_LAST) begin
          shift_d[bit_q] = sync2_q;
          phase_d        = '0;
          state_d        = S_SHIFT_HI;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_SHIFT_HI: begin
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == 4'd15) ? S_DONE : S_SHIFT_LO;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_DONE: begin
`ifdef SNES_READER_DEBOUNCE_EN
        accept = (shift_q == prev_q) && (shift_q != buttons_q);
        prev_d = shift_q;
`else
        accept = 1'b1;
`endif
        if (accept) begin
          buttons_d = shift_q;
          idx_d     = prio_idx(shift_q);
          valid_d   = 1'b1;
        end
        poll_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    latch_d = (state_d == S_LATCH);
    sclk_d  = (state_d != S_SHIFT_LO);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge _d value regardless of statement order.
    if (reset) begin
      state_q   <= S_IDLE;
      poll_q    <= '0;
      phase_q   <= '0;
      bit_q     <= '0;
      shift_q   <= 16'hFFFF;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      buttons_q <= 16'hFFFF;
      idx_q     <= 4'hF;
      valid_q   <= 1'b0;
      latch_q   <= 1'b0;
      sclk_q    <= 1'b1;
      busy_q    <= 1'b0;
`ifdef SNES_READER_DEBOUNCE_EN
      prev_q    <= 16'hFFFF;
`endif
    end else begin
      state_q   <= state_d;
      poll_q    <= poll_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      buttons_q <= buttons_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      latch_q   <= latch_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
`ifdef SNES_READER_DEBOUNCE_EN
      prev_q    <= prev_d;
`endif
    end
  end

  assign snes_latch = latch_q;
  assign snes_clk   = sclk_q;
  assign buttons    = buttons_q;
  assign button_idx = idx_q;
  assign valid      = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_snes_reader.sv
// tb_snes_reader: self-checking bench for snes_reader with HALF_CYC=4,
// POLL_CYC=50, a behavioural pad model and a frame-level reference model.
module tb_snes_reader;

  localparam int HALF = 4;
  localparam int POLL = 50;
  localparam int VALID_LAT = 35 * HALF + 1;  // LATCH entry to valid pulse
  localparam int WIN = 160;                  // observation window per frame

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        snes_data;
  logic        snes_latch;
  logic        snes_clk;
  logic [15:0] buttons;
  logic [3:0]  button_idx;
  logic        valid;
  logic        busy;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  snes_reader #(.HALF_CYC(HALF), .POLL_CYC(POLL)) dut (
    .clk        (clk),
    .reset      (reset),
    .snes_data  (snes_data),
    .snes_latch (snes_latch),
    .snes_clk   (snes_clk),
    .buttons    (buttons),
    .button_idx (button_idx),
    .valid      (valid),
    .busy       (busy)
  );

  // Pad model: parallel-load while latch is high, shift on each clock rise.
  logic [15:0] pad_word = 16'hFFFF;
  logic [15:0] pad_sr   = 16'hFFFF;
  always @(posedge snes_latch, posedge snes_clk) begin
    if (snes_latch) pad_sr = pad_word;
    else            pad_sr = {1'b1, pad_sr[15:1]};
  end
  assign snes_data = pad_sr[0];

  // Frame-level reference model.
  logic [15:0] m_buttons = 16'hFFFF;
  logic [15:0] m_prev    = 16'hFFFF;

  function automatic logic [3:0] ref_idx(input logic [15:0] w);
    for (int i = 0; i < 9; i++) begin
      if (w[i] == 1'b0) return 4'(i);
    end
    return 4'hF;
  endfunction

  task automatic model_frame(input logic [15:0] w, output bit acc);
`ifdef SNES_READER_DEBOUNCE_EN
    acc    = (w == m_prev) && (w != m_buttons);
    m_prev = w;
`else
    acc = 1'b1;
`endif
    if (acc) m_buttons = w;
  endtask

  task automatic model_reset();
    m_buttons = 16'hFFFF;
    m_prev    = 16'hFFFF;
  endtask

  // Bounded wait for the latch to rise; returns the edge index or -1.
  task automatic wait_latch(input string name, output int t_l);
    t_l = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (snes_latch) begin
        t_l = cyc;
        break;
      end
    end
    nvec++;
    if (t_l < 0) begin
      nerr++;
      $display("FAIL %s latch_start: no snes_latch rise within 400 cycles", name);
    end
  endtask

  // Run one frame with pad word w and check its outcome against the model.
  task automatic run_frame(input logic [15:0] w, input string name,
                           output int t_l, output int lat_cnt,
                           output int pulses, output int bad);
    bit acc;
    int vcnt, t_v, run;
    logic [15:0] old_buttons;
    bit early_change;
    old_buttons  = m_buttons;
    pad_word     = w;
    model_frame(w, acc);
    wait_latch(name, t_l);
    lat_cnt = 0; pulses = 0; bad = 0; vcnt = 0; t_v = -1; run = 0;
    early_change = 1'b0;
    if (t_l >= 0) begin
      for (int i = 0; i < WIN; i++) begin
        if (i > 0) @(negedge clk);
        if (snes_latch) lat_cnt++;
        if (!snes_clk) run++;
        else if (run > 0) begin
          pulses++;
          if (run != HALF) bad++;
          run = 0;
        end
        if (valid) begin
          vcnt++;
          if (t_v < 0) t_v = cyc;
        end
        if (t_v < 0 && buttons !== old_buttons) early_change = 1'b1;
      end
    end
    nvec++;
    if (vcnt !== (acc ? 1 : 0)) begin
      nerr++;
      $display("FAIL %s valid_count: got %0d cycles, expected %0d", name, vcnt, acc ? 1 : 0);
    end
    if (acc) begin
      nvec++;
      if (t_v - t_l !== VALID_LAT) begin
        nerr++;
        $display("FAIL %s valid_latency: got %0d, expected %0d", name, t_v - t_l, VALID_LAT);
      end
    end
    nvec++;
    if (early_change) begin
      nerr++;
      $display("FAIL %s buttons_hold: buttons changed before valid, expected %h held", name, old_buttons);
    end
    nvec++;
    if (buttons !== m_buttons) begin
      nerr++;
      $display("FAIL %s buttons: got %h, expected %h", name, buttons, m_buttons);
    end
    nvec++;
    if (button_idx !== ref_idx(m_buttons)) begin
      nerr++;
      $display("FAIL %s button_idx: got %h, expected %h", name, button_idx, ref_idx(m_buttons));
    end
  endtask

  task automatic test_reset();
    int t_rel, t_l, lat_cnt, pulses, bad;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nvec++; if (snes_latch !== 1'b0)   begin nerr++; $display("FAIL reset snes_latch: got %b, expected 0", snes_latch); end
    nvec++; if (snes_clk !== 1'b1)     begin nerr++; $display("FAIL reset snes_clk: got %b, expected 1", snes_clk); end
    nvec++; if (buttons !== 16'hFFFF)  begin nerr++; $display("FAIL reset buttons: got %h, expected ffff", buttons); end
    nvec++; if (button_idx !== 4'hF)   begin nerr++; $display("FAIL reset button_idx: got %h, expected f", button_idx); end
    nvec++; if (valid !== 1'b0)        begin nerr++; $display("FAIL reset valid: got %b, expected 0", valid); end
    nvec++; if (busy !== 1'b0)         begin nerr++; $display("FAIL reset busy: got %b, expected 0", busy); end
    model_reset();
    reset = 1'b0;
    t_rel = cyc;
    run_frame(16'hFFFF, "reset_frame", t_l, lat_cnt, pulses, bad);
    nvec++; if (t_l - t_rel !== POLL) begin nerr++; $display("FAIL reset first_latch: got %0d cycles, expected %0d", t_l - t_rel, POLL); end
    nvec++; if (lat_cnt !== 2 * HALF) begin nerr++; $display("FAIL reset latch_width: got %0d, expected %0d", lat_cnt, 2 * HALF); end
    nvec++; if (pulses !== 16)        begin nerr++; $display("FAIL reset clk_pulses: got %0d, expected 16", pulses); end
    nvec++; if (bad !== 0)            begin nerr++; $display("FAIL reset clk_pulse_width: %0d pulses not %0d cycles long", bad, HALF); end
  endtask

  task automatic test_single();
    logic [15:0] words [3];
    int t_l, a, b, c;
    words[0] = 16'hFFF7;
    words[1] = 16'hFFFE;
    words[2] = 16'hFEFF;
    foreach (words[k]) begin
      // Two frames each so a debounced build also accepts the word.
      run_frame(words[k], "single", t_l, a, b, c);
      run_frame(words[k], "single", t_l, a, b, c);
    end
  endtask

  task automatic test_priority();
    int t_l, a, b, c;
    run_frame(16'hFE5F, "prio_5_7_8", t_l, a, b, c);
    run_frame(16'hFE5F, "prio_5_7_8", t_l, a, b, c);
    run_frame(16'hF9FF, "high_bits", t_l, a, b, c);
    run_frame(16'hF9FF, "high_bits", t_l, a, b, c);
  endtask

  task automatic test_no_buttons();
    int t_l, a, b, c;
    run_frame(16'hFFFF, "no_buttons", t_l, a, b, c);
    run_frame(16'hFFFF, "no_buttons", t_l, a, b, c);
  endtask

  task automatic test_debounce();
    int t_l, a, b, c;
    run_frame(16'hFFFE, "debounce_f1", t_l, a, b, c);
    run_frame(16'hFFFD, "debounce_f2", t_l, a, b, c);
    run_frame(16'hFFFD, "debounce_f3", t_l, a, b, c);
  endtask

  task automatic test_reset_mid();
    int t_l, t_rel, falls, a, b, c;
    logic prev;
    pad_word = 16'($urandom) & 16'hFF00;
    wait_latch("reset_mid", t_l);
    falls = 0;
    prev  = 1'b1;
    for (int i = 0; i < 200 && falls < 8; i++) begin
      @(negedge clk);
      if (prev && !snes_clk) falls++;
      prev = snes_clk;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    nvec++; if (snes_clk !== 1'b1)    begin nerr++; $display("FAIL reset_mid snes_clk: got %b, expected 1", snes_clk); end
    nvec++; if (busy !== 1'b0)        begin nerr++; $display("FAIL reset_mid busy: got %b, expected 0", busy); end
    nvec++; if (snes_latch !== 1'b0)  begin nerr++; $display("FAIL reset_mid snes_latch: got %b, expected 0", snes_latch); end
    nvec++; if (valid !== 1'b0)       begin nerr++; $display("FAIL reset_mid valid: got %b, expected 0", valid); end
    nvec++; if (buttons !== 16'hFFFF) begin nerr++; $display("FAIL reset_mid buttons: got %h, expected ffff", buttons); end
    reset = 1'b0;
    t_rel = cyc;
    run_frame(16'hFFFF, "after_reset_mid", t_l, a, b, c);
    nvec++; if (t_l - t_rel !== POLL) begin nerr++; $display("FAIL reset_mid relatch: got %0d cycles, expected %0d", t_l - t_rel, POLL); end
  endtask

  task automatic test_random();
    logic [15:0] w;
    int t_l, a, b, c;
    w = 16'hFFFF;
    for (int k = 0; k < 10; k++) begin
      if (k == 0 || $urandom_range(0, 2) != 0) begin
        w = 16'($urandom);
        if ($urandom_range(0, 3) == 0) w[8:0] = '1;
      end
      run_frame(w, "random", t_l, a, b, c);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_single();
    test_priority();
    test_no_buttons();
    test_debounce();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/snes_reader.md
# snes_reader

Console-side reader for a physical SNES controller port. It periodically drives the latch and serial clock and shifts in the 16-bit active-low button word. It publishes the raw word and a decoded button index (0–8, or 15 for none), so a pressed controller button maps back to the same index that feeds the button encoder. It sits between the controller pads and game/UI logic, running on the system clock.

## Interface
Parameters:
- `HALF_CYC`, default 72: system clocks per SNES half-period (6 µs at 12 MHz). Minimum 4.
- `POLL_CYC`, default 200000: system clocks spent in IDLE between frames (~16.7 ms at 12 MHz). Minimum 1.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `snes_data`, input, 1: serial data from the controller, asynchronous. Low means the button is pressed.
- `snes_latch`, output, 1: latch to the controller, active-high.
- `snes_clk`, output, 1: serial clock to the controller. Idles high.
- `buttons`, output, 16: last accepted frame. Bit i is serial bit i; 0 means pressed. Bits 12–15 are carried through as received.
- `button_idx`, output, 4: index of the lowest-numbered pressed button among bits 0–8, else 4'hF.
- `valid`, output, 1: one-cycle pulse when `buttons`/`button_idx` update.
- `busy`, output, 1: high in every state except IDLE.

## Operation
Input conditioning:
- `snes_data` passes through a two-flop synchronizer.
- Only the synchronized value is sampled.

State machine: IDLE → LATCH → GAP → SHIFT_LO ⇄ SHIFT_HI → DONE → IDLE.
- **IDLE**
  - `snes_latch`=0, `snes_clk`=1.
  - Counts `POLL_CYC` cycles, then enters LATCH.
- **LATCH**
  - `snes_latch`=1 for 2·`HALF_CYC` cycles.
- **GAP**
  - `snes_latch`=0, `snes_clk`=1 for `HALF_CYC` cycles.
  - Bit counter is cleared.
- **SHIFT_LO**
  - `snes_clk`=0 for `HALF_CYC` cycles.
  - On the last cycle, the synchronized data is stored into shift bit [bit counter].
- **SHIFT_HI**
  - `snes_clk`=1 for `HALF_CYC` cycles.
  - On exit, the bit counter increments.
  - If the counter was 15, go to DONE; else go back to SHIFT_LO.
- **DONE** (one cycle)
  - Frame accept logic runs (see Configuration).
  - On accept: `buttons` ← shift register and `button_idx` ← priority decode of the shift register, both registered at the end of DONE; `valid`=1 in the following cycle only.
  - Returns to IDLE.

Priority decode rules:
- Lowest i in 0..8 with bit i = 0 gives `button_idx` = i.
- Bits 9–15 are ignored for the index.
- If none of bits 0–8 is low, `button_idx` = 4'hF.

Multiple buttons pressed:
- The lowest index wins.
- `buttons` still shows all pressed bits.

## Timing
Reset values, applied on a `reset`-high clock edge:
- `snes_latch`=0, `snes_clk`=1
- `buttons`=16'hFFFF, `button_idx`=4'hF
- `valid`=0, `busy`=0
- State IDLE; poll, phase and bit counters = 0
- Shift register = 16'hFFFF; synchronizer flops = 1

Reset and frame timing:
- Reset asserted mid-frame aborts the frame immediately. Outputs keep no partial data, and no `valid` pulse is produced.
- The first LATCH begins `POLL_CYC` cycles after reset deasserts.
- Frame length from LATCH entry to DONE entry: 35·`HALF_CYC` cycles.
- `valid` rises one cycle after DONE.
- Frame period: `POLL_CYC` + 35·`HALF_CYC` + 1 cycles.

Sampling point:
- The sample at the end of SHIFT_LO reflects pad data from 2 cycles earlier.
- The controller changes data on the `snes_clk` rising edge, so data is stable for ≥`HALF_CYC`−2 cycles before the sample. This is why `HALF_CYC` ≥ 4 is required.

Output stability:
- `buttons` and `button_idx` are held constant between `valid` pulses.
- `snes_latch` and `snes_clk` are registered outputs with no glitches.

## Configuration
Macro `SNES_READER_DEBOUNCE_EN`:
- **Defined:** DONE compares the new shift word with the previous frame's word.
  - Outputs update and `valid` pulses only when two consecutive frames are identical and differ from the current `buttons`.
  - The previous-frame register resets to 16'hFFFF.
- **Undefined:** every completed frame updates the outputs and pulses `valid`, even if the value is unchanged.

## Test plan
Run with `HALF_CYC`=4, `POLL_CYC`=50, and a behavioral controller model that presents bit 0 after the latch falls and shifts on each `snes_clk` rise.
- **Reset values:** hold `reset` 3 cycles → all outputs at reset values; first `snes_latch` rise exactly 50 cycles after deassert; latch high 8 cycles; exactly 16 `snes_clk` low pulses of 4 cycles each.
- **Single button:** model word 16'hFFF7 (bit 3 pressed) → `buttons`=16'hFFF7, `button_idx`=3, `valid` a single-cycle pulse 141 cycles after LATCH entry. Repeat for bits 0 and 8 → indices 0 and 8.
- **Priority and high bits:** word 16'hFE5F (bits 5, 7, 8 pressed) → `button_idx`=5. Word 16'hF9FF (bits 9, 10 only) → `button_idx`=4'hF, `buttons`=16'hF9FF.
- **No buttons:** word 16'hFFFF → `button_idx`=4'hF. `valid` pulses every frame without the macro; with the macro, no pulse after reset.
- **Reset mid-frame:** assert `reset` during bit 7 of SHIFT_LO → next cycle `snes_clk`=1, `busy`=0, no `valid`, `buttons` unchanged at 16'hFFFF.
- **Debounce (macro defined):** frames 16'hFFFE, 16'hFFFD, 16'hFFFD → no update after frame 1 or 2; update to `button_idx`=1 with `valid` after frame 3.
